mem_bus_arbiter: RTL and testbench
==================================

Name: mem_bus_arbiter

Overview:
Shares one unified block-wide main memory between the instruction-cache refill port and the data-cache refill/write-back port. It sits between icache/dcache and a single memory model, and replaces the separate imem/dmem instances behind the caches. It uses the caches' existing read/write/address/busywait handshake on both sides. Data-side requests have priority, bounded by a streak limit so instruction fetch cannot starve.

Parameters:
ADDR_W, 28, block address width (byte address >> 4)
DATA_W, 128, block width in bits
MAX_DSTREAK, 4, max consecutive dcache grants while icache is waiting (1..15)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
i_read  in  1  icache block-read request (level, held until i_busywait low)
i_address  in  ADDR_W  icache block address
i_readdata  out  DATA_W  block returned to icache
i_busywait  out  1  stall to icache
d_read  in  1  dcache block-read request
d_write  in  1  dcache block write-back request
d_address  in  ADDR_W  dcache block address
d_writedata  in  DATA_W  dcache write-back block
d_readdata  out  DATA_W  block returned to dcache
d_busywait  out  1  stall to dcache
mem_read  out  1  memory read strobe (registered)
mem_write  out  1  memory write strobe (registered)
mem_address  out  ADDR_W  latched address (registered)
mem_writedata  out  DATA_W  latched write data (registered)
mem_readdata  in  DATA_W  memory read block
mem_busywait  in  1  memory busy

Behaviour:
- States: IDLE, GRANT_D, GRANT_I. Reset (reset=0, async): state=IDLE; mem_read, mem_write, mem_address, mem_writedata, seen_busy, d_streak all 0.
- Requests: i_req=i_read; d_req=d_read|d_write. If d_read and d_write are both high, the transaction is treated as a write.
- IDLE arbitration, evaluated at the clock edge:
  - Only d_req: go to GRANT_D.
  - Only i_req: go to GRANT_I.
  - Both: GRANT_I if d_streak==MAX_DSTREAK, else GRANT_D.
  - Neither: stay in IDLE.
- Grant edge: latch the winner's address, plus write data for a dcache write. Drive mem_read/mem_write to match the winner from the next cycle onward.
- d_streak:
  - +1, saturating, on a GRANT_D taken while i_req is high.
  - Cleared on any GRANT_I.
  - Cleared on a GRANT_D taken while i_req is low.
- Memory contract: memory samples its strobe at an edge, asserts mem_busywait from the following cycle, and drops it when the data or write is complete.
- seen_busy: set on the first GRANT_x cycle with mem_busywait=1; cleared on entry to IDLE.
- done = (state==GRANT_x) & seen_busy & ~mem_busywait.
- Completion cycle:
  - Granted requester's busywait is low for that one cycle.
  - mem_readdata is valid on x_readdata in that cycle.
  - At the next edge: state goes to IDLE and mem_read/mem_write go to 0.
  - Minimum one IDLE cycle between transactions.
- Busywaits, combinational: i_busywait = i_req & ~(done & state==GRANT_I); d_busywait = d_req & ~(done & state==GRANT_D). With no request, busywait is 0.
- i_readdata and d_readdata are both driven from mem_readdata. They are meaningful only on the owner's completion cycle.
- Latency: request high in IDLE at edge k → strobe visible at edge k+1 → completion after memory latency L → back in IDLE one cycle later. Best-case occupancy is L+2 cycles.
- Request dropped mid-grant: the memory transaction still runs to completion, the result is discarded, then IDLE. No strobe glitch.
- Requester changing address or data mid-grant: no effect (values are latched).
- New request arriving in the completion cycle: it is arbitrated from IDLE next cycle, not chained.
- Reset asserted mid-transaction: immediate return to IDLE and strobes low. The memory model must also be reset.

Test Plan:
- Single icache read, addr 0x0000010, memory L=5 → mem_read high 6 cycles; i_busywait low exactly 1 cycle with i_readdata = model block; d_busywait stays 0.
- Single dcache write-back, addr 0x0000020, data 0xDEADBEEF_... → mem_write=1, mem_writedata matches; d_busywait drops after completion; mem_read never asserted.
- i_read and d_read raised in the same cycle → dcache served first, icache second; icache never loses its request.
- dcache issues 6 back-to-back reads with i_read held, MAX_DSTREAK=4 → grant order D,D,D,D,I,D,D; d_streak resets to 0 after the I grant.
- d_read dropped 2 cycles into GRANT_D → memory transaction completes, d_busywait=0, arbiter in IDLE one cycle after mem_busywait falls; a pending i_read is then granted.
- reset pulsed low during GRANT_I (cycle 3 of 5) → strobes 0 asynchronously, state IDLE, d_streak 0; the held i_read is re-granted after reset release and completes normally.

Source files
------------

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one block-wide main memory between icache refill and dcache refill/write-back.
// Latency: strobe one cycle after an IDLE-edge grant, completion after memory latency, then one IDLE cycle.
// Backpressure: requesters stall on busywait until their completion cycle; dcache wins unless its streak is at MAX_DSTREAK.
module mem_bus_arbiter #(
    parameter int ADDR_W      = 28,
    parameter int DATA_W      = 128,
    parameter int MAX_DSTREAK = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_address,
    output logic [DATA_W-1:0] i_readdata,
    output logic              i_busywait,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_address,
    input  logic [DATA_W-1:0] d_writedata,
    output logic [DATA_W-1:0] d_readdata,
    output logic              d_busywait,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_writedata,
    input  logic [DATA_W-1:0] mem_readdata,
    input  logic              mem_busywait
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_D = 2'd1,
        GRANT_I = 2'd2
    } state_t;

    localparam logic [3:0] MAX_S = 4'(MAX_DSTREAK);

    state_t     r_state;
    state_t     w_state_nxt;
    logic       r_seen_busy;
    logic [3:0] r_d_streak;
    logic [3:0] w_streak_inc;
    logic       w_i_req;
    logic       w_d_req;
    logic       w_done;
    logic       w_grant_d;
    logic       w_grant_i;

    assign w_i_req = i_read;
    assign w_d_req = d_read | d_write;

    // Completion only counts once memory has shown it accepted the strobe,
    // otherwise the idle busywait in the first grant cycle would look like "done".
    assign w_done = (r_state != IDLE) & r_seen_busy & ~mem_busywait;

    assign w_streak_inc = (r_d_streak == 4'hF) ? r_d_streak : r_d_streak + 4'd1;

    assign i_busywait = w_i_req & ~(w_done & (r_state == GRANT_I));
    assign d_busywait = w_d_req & ~(w_done & (r_state == GRANT_D));
    assign i_readdata = mem_readdata;
    assign d_readdata = mem_readdata;

    // Next-state: arbitrate only from IDLE, leave a grant only on completion
    always_comb begin
        w_state_nxt = r_state;
        w_grant_d   = 1'b0;
        w_grant_i   = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_d_req && !(w_i_req && (r_d_streak == MAX_S))) begin
                    w_state_nxt = GRANT_D;
                    w_grant_d   = 1'b1;
                end else if (w_i_req) begin
                    w_state_nxt = GRANT_I;
                    w_grant_i   = 1'b1;
                end
            end
            GRANT_D, GRANT_I: begin
                if (w_done) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Grant-edge latching of the memory command and streak bookkeeping
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_read      <= 1'b0;
            mem_write     <= 1'b0;
            mem_address   <= '0;
            mem_writedata <= '0;
            r_d_streak    <= 4'd0;
        end else if (w_grant_d) begin
            // Read and write together is a write-back
            mem_address <= d_address;
            mem_write   <= d_write;
            mem_read    <= ~d_write;
            if (d_write) begin
                mem_writedata <= d_writedata;
            end
            r_d_streak <= w_i_req ? w_streak_inc : 4'd0;
        end else if (w_grant_i) begin
            mem_address <= i_address;
            mem_read    <= 1'b1;
            mem_write   <= 1'b0;
            r_d_streak  <= 4'd0;
        end else if (w_done) begin
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
        end
    end

    // Remember that memory went busy for the current grant
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_seen_busy <= 1'b0;
        end else if (w_done) begin
            r_seen_busy <= 1'b0;
        end else if ((r_state != IDLE) && mem_busywait) begin
            r_seen_busy <= 1'b1;
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: directed scenarios plus randomized traffic against a transaction-level model.
// Latency: memory model is configurable (fixed or random per transaction).
// Backpressure: requesters hold their request until their busywait drops.
module tb_mem_bus_arbiter;

    localparam int MAXD = 4;

    logic         clk;
    logic         reset;
    logic         i_read;
    logic [27:0]  i_address;
    logic [127:0] i_readdata;
    logic         i_busywait;
    logic         d_read;
    logic         d_write;
    logic [27:0]  d_address;
    logic [127:0] d_writedata;
    logic [127:0] d_readdata;
    logic         d_busywait;
    logic         mem_read;
    logic         mem_write;
    logic [27:0]  mem_address;
    logic [127:0] mem_writedata;
    logic [127:0] mem_readdata;
    logic         mem_busywait;

    int checks = 0;
    int errs   = 0;
    int cyc    = 0;

    mem_bus_arbiter #(.ADDR_W(28), .DATA_W(128), .MAX_DSTREAK(MAXD)) dut (
        .clk(clk), .reset(reset),
        .i_read(i_read), .i_address(i_address), .i_readdata(i_readdata), .i_busywait(i_busywait),
        .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_writedata(d_writedata),
        .d_readdata(d_readdata), .d_busywait(d_busywait),
        .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
        .mem_writedata(mem_writedata), .mem_readdata(mem_readdata), .mem_busywait(mem_busywait)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [127:0] blk_init(input logic [27:0] a);
        logic [31:0] w;
        w = {4'h0, a} ^ 32'hC0DE_0000;
        return {w, w, w, w};
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // ---------------- memory environment ----------------
    logic [127:0] env_mem [0:1023];
    bit           env_vld [0:1023];
    logic [3:0]   env_cnt = 4'd0;
    logic         env_blk = 1'b0;
    logic         env_wr;
    logic [9:0]   env_addr;
    logic [127:0] env_wdata;
    logic [127:0] env_rd = '0;
    int           lat_cfg = 5;
    bit           rand_lat = 1'b0;

    assign mem_busywait = (env_cnt != 4'd0);
    assign mem_readdata = env_rd;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            env_cnt <= 4'd0;
            env_blk <= 1'b0;
        end else if (env_cnt != 4'd0) begin
            env_cnt <= env_cnt - 4'd1;
            if (env_cnt == 4'd1) begin
                if (env_wr) begin
                    env_mem[env_addr] <= env_wdata;
                    env_vld[env_addr] <= 1'b1;
                end else begin
                    env_rd <= env_vld[env_addr] ? env_mem[env_addr] : blk_init({18'd0, env_addr});
                end
            end
        end else if ((mem_read || mem_write) && !env_blk) begin
            env_blk   <= 1'b1;
            env_cnt   <= rand_lat ? 4'($urandom_range(1, 5)) : 4'(lat_cfg - 1);
            env_wr    <= mem_write;
            env_addr  <= mem_address[9:0];
            env_wdata <= mem_writedata;
        end else if (!(mem_read || mem_write)) begin
            env_blk <= 1'b0;
        end
    end

    // ---------------- transaction-level reference model ----------------
    logic         m_busy   = 1'b0;
    logic         m_seen   = 1'b0;
    logic         m_who    = 1'b0;   // 1 = icache owns the memory
    logic         m_wr     = 1'b0;
    logic [27:0]  m_addr   = '0;
    logic [127:0] m_wdata  = '0;
    int           m_streak = 0;
    logic [127:0] gold_mem [0:1023];
    bit           gold_vld [0:1023];
    logic         e_done;

    assign e_done = m_busy && m_seen && !mem_busywait;

    function automatic logic [127:0] gold_rd(input logic [27:0] a);
        return gold_vld[a[9:0]] ? gold_mem[a[9:0]] : blk_init(a);
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_busy   <= 1'b0;
            m_seen   <= 1'b0;
            m_streak <= 0;
        end else if (m_busy) begin
            if (mem_busywait) m_seen <= 1'b1;
            if (e_done) begin
                m_busy <= 1'b0;
                m_seen <= 1'b0;
                if (m_wr) begin
                    gold_mem[m_addr[9:0]] <= m_wdata;
                    gold_vld[m_addr[9:0]] <= 1'b1;
                end
            end
        end else if ((d_read || d_write) && !(i_read && m_streak == MAXD)) begin
            m_busy   <= 1'b1;
            m_who    <= 1'b0;
            m_wr     <= d_write;
            m_addr   <= d_address;
            m_wdata  <= d_writedata;
            m_streak <= i_read ? m_streak + 1 : 0;
        end else if (i_read) begin
            m_busy   <= 1'b1;
            m_who    <= 1'b1;
            m_wr     <= 1'b0;
            m_addr   <= i_address;
            m_streak <= 0;
        end
    end

    // Per-cycle comparison of the DUT against the model
    always @(negedge clk) begin
        if (reset) begin
            chk("i_busywait", 128'(i_busywait), 128'(i_read && !(e_done && m_who)));
            chk("d_busywait", 128'(d_busywait), 128'((d_read || d_write) && !(e_done && !m_who)));
            chk("mem_read", 128'(mem_read), 128'(m_busy && !m_wr));
            chk("mem_write", 128'(mem_write), 128'(m_busy && m_wr));
            if (m_busy) chk("mem_address", 128'(mem_address), 128'(m_addr));
            if (m_busy && m_wr) chk("mem_writedata", mem_writedata, m_wdata);
            if (e_done && m_who && i_read) chk("i_readdata", i_readdata, gold_rd(m_addr));
            if (e_done && !m_who && !m_wr && d_read) chk("d_readdata", d_readdata, gold_rd(m_addr));
        end
    end

    // Observer: order/timing of strobes and memory completions
    int   obs_addr [$];
    int   obs_cyc  [$];
    int   fall_cyc [$];
    logic prev_stb  = 1'b0;
    logic prev_busy = 1'b0;

    always @(negedge clk) begin
        if ((mem_read || mem_write) && !prev_stb) begin
            obs_addr.push_back(int'(mem_address));
            obs_cyc.push_back(cyc);
        end
        if (prev_busy && !mem_busywait) fall_cyc.push_back(cyc);
        prev_stb  <= mem_read || mem_write;
        prev_busy <= mem_busywait;
    end

    function automatic int obs_at(input int k);
        return (k < obs_addr.size()) ? obs_addr[k] : -1;
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_i(input logic [27:0] a, output logic [127:0] rd);
        bit ok = 1'b0;
        rd        = '0;
        i_address = a;
        i_read    = 1'b1;
        for (int c = 0; c < 100 && !ok; c++) begin
            @(negedge clk);
            if (!i_busywait) begin
                ok = 1'b1;
                rd = i_readdata;
            end
            step();
        end
        i_read = 1'b0;
        chk("i_request_served", 128'(ok), 128'(1));
    endtask

    task automatic do_d(input logic [27:0] a, input logic rd_en, input logic wr_en,
                        input logic [127:0] wd, output logic [127:0] rd);
        bit ok = 1'b0;
        rd          = '0;
        d_address   = a;
        d_writedata = wd;
        d_read      = rd_en;
        d_write     = wr_en;
        for (int c = 0; c < 100 && !ok; c++) begin
            @(negedge clk);
            if (!d_busywait) begin
                ok = 1'b1;
                rd = d_readdata;
            end
            step();
        end
        d_read  = 1'b0;
        d_write = 1'b0;
        chk("d_request_served", 128'(ok), 128'(1));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        logic [127:0] rdv;
        logic [127:0] rdi;
        logic [127:0] cap;
        int           ob;
        int           fb;
        int           rd_hi;
        int           lowcnt;
        int           dbw;
        int           wr_cnt;
        int           wd_bad;
        int           end_cyc;
        int           exp_order [7];
        logic [127:0] lit_wd;

        reset = 1'b0; i_read = 1'b0; i_address = '0;
        d_read = 1'b0; d_write = 1'b0; d_address = '0; d_writedata = '0;
        lit_wd = 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D;

        // Reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_mem_read", 128'(mem_read), 128'(0));
        chk("rst_mem_write", 128'(mem_write), 128'(0));
        chk("rst_mem_address", 128'(mem_address), 128'(0));
        chk("rst_mem_writedata", mem_writedata, 128'(0));
        chk("rst_i_busywait", 128'(i_busywait), 128'(0));
        chk("rst_d_busywait", 128'(d_busywait), 128'(0));
        @(posedge clk);
        #2 reset = 1'b1;
        step();

        // Single icache read, L=5
        rd_hi = 0; lowcnt = 0; dbw = 0; cap = '0;
        i_address = 28'h0000010;
        i_read    = 1'b1;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (mem_read) rd_hi++;
            if (d_busywait) dbw++;
            if (i_read && !i_busywait) begin
                lowcnt++;
                cap = i_readdata;
            end
            step();
            if (lowcnt != 0) i_read = 1'b0;
        end
        chk("t1_mem_read_cycles", 128'(rd_hi), 128'(6));
        chk("t1_i_busywait_low_cycles", 128'(lowcnt), 128'(1));
        chk("t1_i_readdata", cap, 128'hC0DE0010_C0DE0010_C0DE0010_C0DE0010);
        chk("t1_d_busywait_never", 128'(dbw), 128'(0));

        // Single dcache write-back
        rd_hi = 0; wr_cnt = 0; wd_bad = 0; lowcnt = 0;
        d_address = 28'h0000020; d_writedata = lit_wd; d_write = 1'b1;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (mem_read) rd_hi++;
            if (mem_write) begin
                wr_cnt++;
                if (mem_writedata !== lit_wd) wd_bad++;
            end
            if (d_write && !d_busywait) lowcnt++;
            step();
            if (lowcnt != 0) d_write = 1'b0;
        end
        chk("t2_mem_write_seen", 128'(wr_cnt), 128'(6));
        chk("t2_writedata_bad_cycles", 128'(wd_bad), 128'(0));
        chk("t2_mem_read_never", 128'(rd_hi), 128'(0));
        chk("t2_d_busywait_low_cycles", 128'(lowcnt), 128'(1));
        do_d(28'h0000020, 1'b1, 1'b0, '0, rdv);
        chk("t2_readback", rdv, lit_wd);

        // Simultaneous icache and dcache requests: dcache first
        ob = obs_addr.size();
        fork
            do_d(28'h0000040, 1'b1, 1'b0, '0, rdv);
            do_i(28'h0000041, rdi);
        join
        chk("t3_first_grant", 128'(obs_at(ob)), 128'(32'h40));
        chk("t3_second_grant", 128'(obs_at(ob + 1)), 128'(32'h41));
        chk("t3_i_data", rdi, 128'hC0DE0041_C0DE0041_C0DE0041_C0DE0041);

        // Streak limit: six back-to-back dcache reads with icache waiting
        ob = obs_addr.size();
        fork
            begin
                for (int k = 0; k < 6; k++) do_d(28'h200 + 28'(k), 1'b1, 1'b0, '0, rdv);
            end
            do_i(28'h0000100, rdi);
        join
        exp_order = '{32'h200, 32'h201, 32'h202, 32'h203, 32'h100, 32'h204, 32'h205};
        for (int k = 0; k < 7; k++) chk($sformatf("t4_order_%0d", k), 128'(obs_at(ob + k)), 128'(exp_order[k]));

        // dcache drops its read two cycles into the grant, icache pending
        ob = obs_addr.size();
        fb = fall_cyc.size();
        fork
            begin
                d_address = 28'h0000050;
                d_read    = 1'b1;
                for (int c = 0; c < 20; c++) begin
                    @(negedge clk);
                    if (mem_read) break;
                end
                step();
                step();
                d_read = 1'b0;
            end
            do_i(28'h0000051, rdi);
        join
        chk("t5_first_grant", 128'(obs_at(ob)), 128'(32'h50));
        chk("t5_second_grant", 128'(obs_at(ob + 1)), 128'(32'h51));
        if (fall_cyc.size() > fb && obs_cyc.size() > ob + 1)
            chk("t5_regrant_gap", 128'(obs_cyc[ob + 1] - fall_cyc[fb]), 128'(2));
        else
            chk("t5_events_present", 128'(0), 128'(1));
        chk("t5_i_data", rdi, 128'hC0DE0051_C0DE0051_C0DE0051_C0DE0051);

        // Reset pulsed during an icache grant
        ob = obs_addr.size();
        i_address = 28'h0000060;
        i_read    = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (mem_read) break;
        end
        @(posedge clk);
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        chk("t6_rst_mem_read", 128'(mem_read), 128'(0));
        chk("t6_rst_mem_write", 128'(mem_write), 128'(0));
        chk("t6_rst_mem_address", 128'(mem_address), 128'(0));
        chk("t6_rst_i_busywait", 128'(i_busywait), 128'(1));
        @(posedge clk);
        #2 reset = 1'b1;
        do_i(28'h0000060, rdi);
        chk("t6_i_data", rdi, 128'hC0DE0060_C0DE0060_C0DE0060_C0DE0060);
        chk("t6_regranted", 128'(obs_at(ob + 1)), 128'(32'h60));

        // Randomized traffic
        rand_lat = 1'b1;
        end_cyc  = cyc + 1500;
        fork
            begin
                while (cyc < end_cyc) begin
                    repeat ($urandom_range(0, 3)) step();
                    do_i(28'($urandom_range(0, 15)), rdi);
                end
            end
            begin
                int k;
                while (cyc < end_cyc) begin
                    repeat ($urandom_range(0, 3)) step();
                    k = $urandom_range(0, 7);
                    if (k == 0) begin
                        d_address = 28'($urandom_range(0, 15));
                        d_read    = 1'b1;
                        repeat ($urandom_range(1, 3)) step();
                        d_read = 1'b0;
                        for (int c = 0; c < 100; c++) begin
                            @(negedge clk);
                            if (!mem_read && !mem_write) break;
                        end
                        step();
                    end else begin
                        do_d(28'($urandom_range(0, 15)), k < 4 || k == 7, k >= 4,
                             {$urandom, $urandom, $urandom, $urandom}, rdv);
                    end
                end
            end
        join
        repeat (20) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errs);
        $finish;
    end

endmodule
